// File: rtl/clk_div_bank.sv
// Bank of NCH programmable clock dividers (toggle or pulse output) with a shared config port.
// Outputs registered, one cycle after the deciding edge; cfg_ready drops for the cycle after each accepted request.
module clk_div_bank #(
   parameter int NCH     = 2,
   parameter int CNT_W   = 16,
   parameter int DEF_DIV = 8
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic [NCH-1:0]   en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [2:0]       cfg_ch,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic             cfg_mode,
   output logic             cfg_err,
   output logic [NCH-1:0]   clk_out,
   output logic [NCH-1:0]   tick
);

   typedef struct packed {
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] div;
      logic             mode;
   } chan_t;

   chan_t          chan_q [NCH];
   logic           cfg_acc;
   logic           cfg_bad;
   logic [NCH-1:0] load_sel;

   assign cfg_acc = cfg_valid && cfg_ready;
   assign cfg_bad = {1'b0, cfg_ch} >= 4'(NCH);

   // An out-of-range index never matches any channel, so a bad request touches no state.
   always_comb begin
      load_sel = '0;
      for (int i = 0; i < NCH; i++) begin
         load_sel[i] = cfg_acc && (cfg_ch == 3'(i));
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         cfg_ready <= 1'b1;
         cfg_err   <= 1'b0;
         clk_out   <= '0;
         tick      <= '0;
         for (int i = 0; i < NCH; i++) begin
            chan_q[i].cnt  <= '0;
            chan_q[i].div  <= CNT_W'(DEF_DIV);
            chan_q[i].mode <= 1'b0;
         end
      end else begin
         cfg_ready <= !cfg_acc;
         cfg_err   <= cfg_acc && cfg_bad;
         for (int i = 0; i < NCH; i++) begin
            if (load_sel[i]) begin
               // A load wins over this edge's count/terminal-count update.
               chan_q[i].cnt  <= '0;
               chan_q[i].div  <= cfg_div;
               chan_q[i].mode <= cfg_mode;
               clk_out[i]     <= 1'b0;
               tick[i]        <= 1'b0;
            end else if (en[i]) begin
               if (chan_q[i].cnt == chan_q[i].div) begin
                  chan_q[i].cnt <= '0;
                  tick[i]       <= 1'b1;
                  clk_out[i]    <= chan_q[i].mode ? 1'b1 : !clk_out[i];
               end else begin
                  chan_q[i].cnt <= chan_q[i].cnt + CNT_W'(1);
                  tick[i]       <= 1'b0;
                  clk_out[i]    <= chan_q[i].mode ? 1'b0 : clk_out[i];
               end
            end else begin
               tick[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: directed scenarios then random traffic against an arithmetic reference model.
module tb_clk_div_bank;
   localparam int NCH   = 2;
   localparam int CNT_W = 16;

   logic             clk_in;
   logic             reset;
   logic [NCH-1:0]   en;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [2:0]       cfg_ch;
   logic [CNT_W-1:0] cfg_div;
   logic             cfg_mode;
   logic             cfg_err;
   logic [NCH-1:0]   clk_out;
   logic [NCH-1:0]   tick;

   int checks = 0;
   int errors = 0;

   // Reference model: per channel, the number of enabled edges since the last (re)load.
   longint         m_pos  [NCH];
   int             m_div  [NCH];
   bit             m_mode [NCH];
   logic [NCH-1:0] m_out;
   logic [NCH-1:0] m_tick;
   logic           m_rdy;
   logic           m_err;

   clk_div_bank #(.NCH(NCH), .CNT_W(CNT_W), .DEF_DIV(8)) dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_mode  (cfg_mode),
      .cfg_err   (cfg_err),
      .clk_out   (clk_out),
      .tick      (tick)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   task automatic model_edge();
      bit acc;
      bit fire;
      if (reset) begin
         m_rdy  = 1'b1;
         m_err  = 1'b0;
         m_out  = '0;
         m_tick = '0;
         for (int i = 0; i < NCH; i++) begin
            m_pos[i] = 0; m_div[i] = 8; m_mode[i] = 1'b0;
         end
         return;
      end
      acc   = cfg_valid && m_rdy;
      m_err = acc && (int'(cfg_ch) >= NCH);
      m_rdy = !acc;
      for (int i = 0; i < NCH; i++) begin
         if (acc && int'(cfg_ch) == i) begin
            m_div[i] = int'(cfg_div); m_mode[i] = cfg_mode; m_pos[i] = 0;
            m_out[i] = 1'b0; m_tick[i] = 1'b0;
         end else if (en[i]) begin
            fire = (m_pos[i] % (m_div[i] + 1)) == m_div[i];
            m_pos[i]++;
            m_tick[i] = fire;
            // Toggle output level = parity of terminal counts seen so far.
            m_out[i] = m_mode[i] ? fire : 1'((m_pos[i] / (m_div[i] + 1)) % 2);
         end else begin
            m_tick[i] = 1'b0;
         end
      end
   endtask

   task automatic check(input string tag);
      checks++;
      assert (clk_out === m_out) else begin
         errors++; $error("FAIL %s clk_out got %b exp %b", tag, clk_out, m_out);
      end
      checks++;
      assert (tick === m_tick) else begin
         errors++; $error("FAIL %s tick got %b exp %b", tag, tick, m_tick);
      end
      checks++;
      assert (cfg_ready === m_rdy) else begin
         errors++; $error("FAIL %s cfg_ready got %b exp %b", tag, cfg_ready, m_rdy);
      end
      checks++;
      assert (cfg_err === m_err) else begin
         errors++; $error("FAIL %s cfg_err got %b exp %b", tag, cfg_err, m_err);
      end
   endtask

   task automatic cycle(input string tag, input logic [NCH-1:0] e, input logic v,
                        input logic [2:0] ch, input logic [CNT_W-1:0] d,
                        input logic m, input logic r);
      en = e; cfg_valid = v; cfg_ch = ch; cfg_div = d; cfg_mode = m; reset = r;
      @(posedge clk_in);
      model_edge();
      #1;
      check(tag);
   endtask

   initial begin
      int lat;
      bit found;
      logic [NCH-1:0]   re;
      logic             rv;
      logic [2:0]       rch;
      logic [CNT_W-1:0] rd;
      logic             rm;
      logic             rr;

      en = '0; cfg_valid = 0; cfg_ch = '0; cfg_div = '0; cfg_mode = 0; reset = 1;
      #1;
      cycle("reset", 2'b11, 1'b1, 3'd0, 16'd3, 1'b1, 1'b1);
      cycle("reset", 2'b00, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
      cycle("reset_rel", 2'b00, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);

      // Count ch0 to cnt=5, freeze it, then measure the re-enable latency to its first tick.
      for (int k = 0; k < 5; k++) cycle("pre_freeze", 2'b11, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) cycle("freeze", 2'b10, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      lat = -1;
      for (int k = 1; k <= 12; k++) begin
         cycle("resume", 2'b11, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
         if (lat < 0 && tick[0] === 1'b1) lat = k;
      end
      checks++;
      assert (lat === 4) else begin
         errors++; $error("FAIL resume_latency got %0d exp %0d", lat, 4);
      end

      for (int k = 0; k < 40; k++) cycle("default_div", 2'b11, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);

      // ch1 to pulse mode div=2; valid held a second cycle lands in the not-ready slot.
      cycle("cfg_ch1", 2'b11, 1'b1, 3'd1, 16'd2, 1'b1, 1'b0);
      cycle("cfg_busy", 2'b11, 1'b1, 3'd1, 16'd5, 1'b0, 1'b0);
      for (int k = 0; k < 15; k++) cycle("ch1_pulse", 2'b11, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);

      cycle("cfg_bad_ch", 2'b11, 1'b1, 3'd5, 16'd1, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) cycle("after_bad", 2'b11, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);

      // Configure ch0 exactly on its terminal-count edge.
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (m_rdy && (m_pos[0] % (m_div[0] + 1)) == m_div[0]) found = 1;
         else cycle("seek_tc", 2'b11, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      end
      checks++;
      assert (found === 1'b1) else begin
         errors++; $error("FAIL seek_tc_bound got %b exp %b", found, 1'b1);
      end
      cycle("cfg_on_tc", 2'b11, 1'b1, 3'd0, 16'd4, 1'b0, 1'b0);
      for (int k = 0; k < 14; k++) cycle("after_tc_cfg", 2'b11, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);

      cycle("cfg_div0", 2'b11, 1'b1, 3'd0, 16'd0, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) cycle("div0_toggle", 2'b11, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);

      // Reset mid-count, with a request pending in the cfg_ready=0 cycle.
      cycle("cfg_pre_rst", 2'b11, 1'b1, 3'd1, 16'd3, 1'b0, 1'b0);
      cycle("rst_mid", 2'b11, 1'b1, 3'd0, 16'd1, 1'b1, 1'b1);
      for (int k = 0; k < 20; k++) cycle("post_rst", 2'b11, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);

      for (int k = 0; k < 600; k++) begin
         re  = NCH'($urandom);
         rv  = ($urandom_range(0, 2) == 0);
         rch = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
         rd  = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 40)) : CNT_W'($urandom_range(0, 5));
         rm  = 1'($urandom);
         rr  = ($urandom_range(0, 99) == 0);
         cycle("random", re, rv, rch, rd, rm, rr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
